// File: rtl/mux16_pkg.sv
// Shared constants and types for the mux16 control blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mux16_pkg;

  localparam int N_CH  = 16;
  localparam int SEL_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Channel index to one-hot grant vector.
  function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_CH'(1) << idx;
  endfunction

endpackage

// File: rtl/mux16_rr_arbiter_if.sv
// Request/grant bundle between the mux16 requesters and the arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req until granted; done/req drop end a grant.
interface mux16_rr_arbiter_if;
  import mux16_pkg::*;

  logic [N_CH-1:0]  req;
  logic             done;
  logic [SEL_W-1:0] sel;
  logic [N_CH-1:0]  gnt;
  logic             gnt_valid;
  logic             timeout;

  // Requester side.
  modport master (
    output req, done,
    input  sel, gnt, gnt_valid, timeout
  );

  // Arbiter side.
  modport slave (
    input  req, done,
    output sel, gnt, gnt_valid, timeout
  );

endinterface

// File: rtl/rr_pick16.sv
// Round-robin pick: first set req bit at or above ptr, scanning upward mod 16.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request is set.
module rr_pick16
  import mux16_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] index
);

  logic [SEL_W-1:0] cand;

  // Walk offsets from the far end down so the nearest offset from ptr wins;
  // the 4-bit add wraps the scan past channel 15 back to channel 0.
  always_comb begin
    found = |req;
    index = '0;
    cand  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        index = cand;
      end
    end
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter for a 16:1 mux; sel drives the mux16 select directly.
// Latency: grant registered one edge after req seen in IDLE; one idle cycle between grants.
// Backpressure: grant held until done, req[sel] drop, or HOLD_MAX cycles (then timeout pulse).
module mux16_rr_arbiter
  import mux16_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input logic              clk,
  input logic              rst,
  mux16_rr_arbiter_if.slave bus
);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SEL_W-1:0] sel, sel_nxt;
  logic [N_CH-1:0]  gnt, gnt_nxt;
  logic             gnt_valid, gnt_valid_nxt;
  logic             timeout, timeout_nxt;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             rel_owner;
  logic             rel_limit;

  rr_pick16 u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  // Next-state and registered-output values; owner release (done or req drop)
  // outranks the hold limit, so timeout only fires on a pure limit release.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    cnt_nxt       = cnt;
    sel_nxt       = sel;
    gnt_nxt       = gnt;
    gnt_valid_nxt = gnt_valid;
    timeout_nxt   = 1'b0;
    rel_owner     = bus.done || !bus.req[sel];
    rel_limit     = (cnt == CNT_W'(HOLD_MAX - 1));
    case (state)
      IDLE: begin
        gnt_nxt       = '0;
        gnt_valid_nxt = 1'b0;
        if (pick_found) begin
          state_nxt     = GRANT;
          sel_nxt       = pick_idx;
          gnt_nxt       = onehot(pick_idx);
          gnt_valid_nxt = 1'b1;
          cnt_nxt       = '0;
        end
      end
      GRANT: begin
        if (rel_owner || rel_limit) begin
          state_nxt     = IDLE;
          ptr_nxt       = sel + SEL_W'(1);
          cnt_nxt       = '0;
          gnt_nxt       = '0;
          gnt_valid_nxt = 1'b0;
          timeout_nxt   = !rel_owner;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset wins over any grant in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      sel       <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      sel       <= sel_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= gnt_valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

  assign bus.sel       = sel;
  assign bus.gnt       = gnt;
  assign bus.gnt_valid = gnt_valid;
  assign bus.timeout   = timeout;

endmodule

// File: doc/mux16_rr_arbiter.md
MUX16_RR_ARBITER -- requirements
Module: mux16_rr_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 8: maximum cycles one grant is held before forced release (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req  input  16  per-channel request; bit i = channel i wants the mux16 output.
REQ-005 SHALL have port done  input  1  the current owner releases its grant; ignored when gnt_valid=0.
REQ-006 SHALL have port sel  output  4  index of the granted channel; drives mux16 sel directly.
REQ-007 SHALL have port gnt  output  16  one-hot grant; all-zero when no grant.
REQ-008 SHALL have port gnt_valid  output  1  a grant is active; sel is meaningful only while this is high.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse when a grant is force-released by the HOLD_MAX limit.

Function
REQ-010 SHALL register all outputs, with no combinational path from any input to any output.
REQ-011 SHALL implement FSM states IDLE and GRANT.
REQ-012 In IDLE with req != 0 at a rising edge, SHALL move to GRANT at that edge and load sel/gnt with the winning channel: first set req bit at or above ptr, scanning upward mod 16.
REQ-013 In IDLE with req == 0, SHALL stay in IDLE with sel unchanged and gnt = 0.
REQ-014 In GRANT, SHALL hold sel/gnt constant and increment hold counter cnt, starting at 0 on entry.
REQ-015 SHALL release GRANT → IDLE at an edge when done=1, or req[sel]=0, or cnt==HOLD_MAX-1 (a grant lasts at most HOLD_MAX cycles).
REQ-016 On release, SHALL set ptr = sel+1 mod 16 (wrap 15→0).
REQ-017 timeout SHALL be 1 for exactly the cycle after a release caused only by the count limit; done or req drop on the same edge takes precedence, so timeout stays 0.
REQ-018 SHALL spend at least one IDLE cycle between consecutive grants, i.e. gnt_valid low ≥1 cycle, as the mux settling gap.
REQ-019 Request latency: req sampled high at edge k in IDLE SHALL give gnt_valid=1 after edge k.
REQ-020 Changes to req bits other than req[sel] during GRANT SHALL NOT affect the current grant.
REQ-021 gnt SHALL equal (1 << sel) whenever gnt_valid=1, and 0 otherwise.
REQ-022 With all 16 requests held continuously, channels SHALL be granted in strict order 0,1,…,15,0; no channel waits more than 15 grants.

Reset
REQ-023 With rst=1 at a rising edge, SHALL set state=IDLE, ptr=0, cnt=0, sel=0, gnt=0, gnt_valid=0, timeout=0.
REQ-024 rst SHALL take priority over all other inputs, including mid-grant; the grant ends at that edge and is not resumed.
REQ-025 The first grant after reset SHALL favour channel 0.

Structure
REQ-026 SHALL take N_CH=16, SEL_W=4, CNT_W=8 and the state encoding (IDLE=0, GRANT=1) from shared package mux16_pkg.
REQ-027 SHALL place the combinational round-robin pick (req, ptr → found, index) in sub-module rr_pick16, reusable by other mux16 controllers.
REQ-028 A top-level wrapper SHALL connect sel to mux16 and leave the mux16 datapath unchanged.

Verification
REQ-029 The bench SHALL cover: rst=1 for 2 cycles then req=16'h0000 → gnt_valid=0, sel=0, gnt=0 for 10 cycles.
REQ-030 The bench SHALL cover: req=16'h0014 from reset, done pulsed 2 cycles after each grant → sel sequence 2, 4, 2, with 1 idle cycle between grants.
REQ-031 The bench SHALL cover: req=16'hFFFF held, done never asserted, HOLD_MAX=8 → each grant lasts 8 cycles with a timeout pulse after each, and sel runs 0..15 then wraps to 0.
REQ-032 The bench SHALL cover: req=16'h8001, grant on 15 (ptr=15), then done → next grant is channel 0 (wrap-around).
REQ-033 The bench SHALL cover: grant on channel 3, req[3] dropped while req[5]=1 → release next edge, timeout=0, then sel=5.
REQ-034 The bench SHALL cover: rst=1 asserted during a channel-7 grant → next cycle gnt_valid=0, ptr=0, and with req=16'h0081 the next grant is channel 0.
